// File: rtl/miner_host_pkg.sv
// Shared types and constants for the miner host: FSM states, transfer sizes and
// the bit positions used on the device handshake lines.
package miner_host_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrRqHi,
    StWrRqLo,
    StWaitDone,
    StRdRqHi,
    StRdRqLo,
    StFin,
    StErr
  } state_e;

  localparam int unsigned HDR_WORDS  = 40;
  localparam int unsigned HASH_BYTES = 32;
  localparam int unsigned RQ_BIT     = 7;
  localparam int unsigned DONE_BIT   = 6;
  localparam int unsigned ACK_BIT    = 7;

endpackage

// File: rtl/bit_sync.sv
// Multi-bit flop chain bringing asynchronous device outputs into the clk domain.
// STAGES must be at least 2.
module bit_sync #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];

  always_comb begin
    sync_d[0] = d_i;
    for (int i = 1; i < int'(STAGES); i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < int'(STAGES); i++) begin
      if (rst_i) begin
        sync_q[i] <= '0;
      end else begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/miner_host.sv
// Host side of the miner device link: streams a 640-bit header to the device as
// 40 request/response words, then collects 32 hash bytes using an rq/ack handshake.
module miner_host
  import miner_host_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1048576
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [639:0] header,
  output logic         busy,
  output logic         hash_valid,
  output logic [255:0] hash,
  output logic         error,
  output logic [31:0]  cycle_count,
  output logic [7:0]   dev_ui,
  output logic [7:0]   dev_uio_in,
  input  logic [7:0]   dev_uo,
  input  logic [7:0]   dev_uio_out
);

  localparam logic [31:0] WaitLast  = 32'(TIMEOUT - 1);
  localparam logic [5:0]  LastWord  = 6'(HDR_WORDS - 1);
  localparam logic [5:0]  AddrLimit = 6'(HASH_BYTES);

  logic [15:0] dev_sync;
  logic [7:0]  uo_s, rd_data;
  logic        rq, done_s;
  logic [5:0]  addr;

  bit_sync #(
    .WIDTH (16),
    .STAGES(SYNC_STAGES)
  ) u_bit_sync (
    .clk_i(clk),
    .rst_i(rst),
    .d_i  ({dev_uo, dev_uio_out}),
    .q_o  (dev_sync)
  );

  assign uo_s    = dev_sync[15:8];
  assign rd_data = dev_sync[7:0];
  assign rq      = uo_s[RQ_BIT];
  assign done_s  = uo_s[DONE_BIT];
  assign addr    = uo_s[5:0];

  state_e        state_q, state_d;
  logic [639:0]  hdr_q, hdr_d;
  logic [5:0]    idx_q, idx_d;
  logic [255:0]  hash_q, hash_d;
  logic          hash_valid_q, hash_valid_d;
  logic          error_q, error_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [7:0]    ui_q, ui_d;
  logic [7:0]    uio_q, uio_d;
  logic [31:0]   wait_q, wait_d;
  logic          busy_s;

  assign busy_s = (state_q != StIdle) && (state_q != StErr);

  always_comb begin
    state_d      = state_q;
    hdr_d        = hdr_q;
    idx_d        = idx_q;
    hash_d       = hash_q;
    hash_valid_d = hash_valid_q;
    error_d      = error_q;
    cnt_d        = cnt_q;
    ui_d         = ui_q;
    uio_d        = uio_q;

    if (busy_s && (cnt_q != '1)) begin
      cnt_d = cnt_q + 32'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          hdr_d        = header;
          hash_d       = '0;
          hash_valid_d = 1'b0;
          error_d      = 1'b0;
          cnt_d        = '0;
          idx_d        = '0;
          state_d      = StWrRqHi;
        end
      end
      StWrRqHi: begin
        // hdr_q is shifted per word so the current word always sits at the top.
        if (rq) begin
          ui_d    = hdr_q[639:632];
          uio_d   = hdr_q[631:624];
          state_d = StWrRqLo;
        end
      end
      StWrRqLo: begin
        if (!rq) begin
          idx_d   = idx_q + 6'd1;
          hdr_d   = {hdr_q[623:0], 16'h0000};
          state_d = (idx_q == LastWord) ? StWaitDone : StWrRqHi;
        end
      end
      StWaitDone: begin
        ui_d  = '0;
        uio_d = '0;
        if (done_s) begin
          state_d = StRdRqHi;
        end
      end
      StRdRqHi: begin
        if (addr >= AddrLimit) begin
          state_d = StFin;
        end else if (rq) begin
          for (int k = 0; k < int'(HASH_BYTES); k++) begin
            if (addr[4:0] == 5'(k)) begin
              hash_d[255-8*k -: 8] = rd_data;
            end
          end
          ui_d          = '0;
          ui_d[ACK_BIT] = 1'b1;
          uio_d         = '0;
          state_d       = StRdRqLo;
        end
      end
      StRdRqLo: begin
        if (!rq) begin
          ui_d    = '0;
          state_d = StRdRqHi;
        end
      end
      StFin: begin
        hash_valid_d = 1'b1;
        state_d      = StIdle;
      end
      StErr: begin
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if ((state_q inside {StWrRqHi, StWrRqLo, StWaitDone, StRdRqHi, StRdRqLo}) &&
        (state_d == state_q) && (wait_q == WaitLast)) begin
      state_d = StErr;
      error_d = 1'b1;
      ui_d    = '0;
      uio_d   = '0;
    end

    if (abort) begin
      state_d      = StIdle;
      hash_valid_d = 1'b0;
      error_d      = 1'b0;
      ui_d         = '0;
      uio_d        = '0;
    end

    wait_d = (state_d != state_q) ? '0 : wait_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      hdr_q        <= '0;
      idx_q        <= '0;
      hash_q       <= '0;
      hash_valid_q <= 1'b0;
      error_q      <= 1'b0;
      cnt_q        <= '0;
      ui_q         <= '0;
      uio_q        <= '0;
      wait_q       <= '0;
    end else begin
      state_q      <= state_d;
      hdr_q        <= hdr_d;
      idx_q        <= idx_d;
      hash_q       <= hash_d;
      hash_valid_q <= hash_valid_d;
      error_q      <= error_d;
      cnt_q        <= cnt_d;
      ui_q         <= ui_d;
      uio_q        <= uio_d;
      wait_q       <= wait_d;
    end
  end

  assign busy        = busy_s;
  assign hash_valid  = hash_valid_q;
  assign hash        = hash_q;
  assign error       = error_q;
  assign cycle_count = cnt_q;
  assign dev_ui      = ui_q;
  assign dev_uio_in  = uio_q;

endmodule

// File: tb/tb_miner_host.sv
// Directed bench for miner_host with a behavioural miner device on the far side.
module tb_miner_host;

  typedef logic [639:0] v_t;
  typedef enum int {MIdle, MWaitStart, MWrHi, MWrLo, MRdAck, MRdNack, MHalt} mstate_e;

  logic         clk = 1'b0;
  logic         rst, start, abort;
  logic [639:0] header;
  logic         busy, hash_valid, error;
  logic [255:0] hash;
  logic [31:0]  cycle_count;
  logic [7:0]   dev_ui, dev_uio_in;
  logic [7:0]   dev_uo = 8'h00;
  logic [7:0]   dev_uio_out = 8'h00;

  always #5 clk = ~clk;

  miner_host #(
    .SYNC_STAGES(2),
    .TIMEOUT    (64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .header     (header),
    .busy       (busy),
    .hash_valid (hash_valid),
    .hash       (hash),
    .error      (error),
    .cycle_count(cycle_count),
    .dev_ui     (dev_ui),
    .dev_uio_in (dev_uio_in),
    .dev_uo     (dev_uo),
    .dev_uio_out(dev_uio_out)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input v_t got, input v_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Device model: 8-cycle rq high/low per header word, then rq/ack per hash byte.
  mstate_e      ms = MIdle;
  int           model_gen = 0, seen_gen = 0, model_stop = -1;
  int           mcnt = 0, mword = 0, mbyte = 0, ack_count = 0, drop_cyc = 0;
  logic         in_read = 1'b0, ack_prev = 1'b0;
  logic [639:0] rx_block = '0;

  always @(negedge clk) begin
    if (in_read && dev_ui[7] && !ack_prev) ack_count++;
    ack_prev = dev_ui[7];
    if (model_gen != seen_gen) begin
      seen_gen = model_gen;
      ms = MWaitStart;
      mcnt = 0; mword = 0; mbyte = 0; ack_count = 0; in_read = 1'b0;
      rx_block = '0; dev_uo = 8'h00; dev_uio_out = 8'h00;
    end else begin
      case (ms)
        MWaitStart: if (busy) begin dev_uo = 8'h80; mcnt = 0; ms = MWrHi; end
        MWrHi: begin
          mcnt++;
          if (mcnt == 8) begin
            rx_block[639-16*mword -: 16] = {dev_ui, dev_uio_in};
            dev_uo = 8'h00; mcnt = 0; drop_cyc = cyc; ms = MWrLo;
          end
        end
        MWrLo: begin
          mcnt++;
          if (mcnt == 8) begin
            mcnt = 0; mword++;
            if (mword == 40) begin
              dev_uo = 8'hC0; dev_uio_out = 8'hA0; in_read = 1'b1; ms = MRdAck;
            end else if (model_stop >= 0 && mword > model_stop) begin
              ms = MHalt;
            end else begin
              dev_uo = 8'h80; ms = MWrHi;
            end
          end
        end
        MRdAck: if (dev_ui[7]) begin dev_uo[7] = 1'b0; ms = MRdNack; end
        MRdNack: if (!dev_ui[7]) begin
          mbyte++;
          if (mbyte == 32) begin
            dev_uo = {2'b01, 6'd32}; ms = MHalt;
          end else begin
            dev_uo = {2'b11, 6'(mbyte)}; dev_uio_out = 8'hA0 + 8'(mbyte); ms = MRdAck;
          end
        end
        default: ;
      endcase
    end
  end

  logic [639:0] genesis, header2;
  logic [255:0] exp_hash;
  logic         first_hv;
  logic [255:0] first_hash;
  logic [31:0]  first_cnt;
  int           n, guard;

  task automatic arm_model(input int stop);
    model_stop = stop;
    model_gen++;
    repeat (4) @(negedge clk);
  endtask

  // n counts negedges after the start drive; hash_valid rises n-1 edges after acceptance.
  task automatic run_job(input logic [639:0] hdr, input int hold, output int cnt);
    header = hdr;
    start = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin first_hv = hash_valid; first_hash = hash; first_cnt = cycle_count; end
      if (cnt >= hold) start = 1'b0;
    end while (hash_valid !== 1'b1 && cnt < 4000);
    start = 1'b0;
    check("job_done", v_t'(hash_valid), v_t'(1'b1));
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    genesis = {32'h01000000, 256'h0,
               256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
               32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c};
    header2 = ~genesis;
    exp_hash = 256'ha0a1a2a3a4a5a6a7a8a9aaabacadaeafb0b1b2b3b4b5b6b7b8b9babbbcbdbebf;
    rst = 1'b1; start = 1'b0; abort = 1'b0; header = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", v_t'(busy), v_t'(1'b0));
    check("rst_hash_valid", v_t'(hash_valid), v_t'(1'b0));
    check("rst_error", v_t'(error), v_t'(1'b0));
    check("rst_hash", v_t'(hash), v_t'(0));
    check("rst_cycle_count", v_t'(cycle_count), v_t'(0));
    check("rst_dev_ui", v_t'(dev_ui), v_t'(0));
    check("rst_dev_uio_in", v_t'(dev_uio_in), v_t'(0));

    // Genesis header end to end
    arm_model(-1);
    run_job(genesis, 1, n);
    check("first_word_ui", v_t'(rx_block[639:632]), v_t'(8'h01));
    check("first_word_uio", v_t'(rx_block[631:624]), v_t'(8'h00));
    check("last_word", v_t'(rx_block[15:0]), v_t'(16'h2b7c));
    check("rx_block", rx_block, genesis);
    check("hash", v_t'(hash), v_t'(exp_hash));
    check("busy_after_fin", v_t'(busy), v_t'(1'b0));
    check("ack_count", v_t'(ack_count), v_t'(32));
    check("error_after_fin", v_t'(error), v_t'(1'b0));
    check("dev_ui_after_fin", v_t'(dev_ui), v_t'(0));
    repeat (10) @(negedge clk);
    check("hash_valid_hold", v_t'(hash_valid), v_t'(1'b1));
    check("hash_hold", v_t'(hash), v_t'(exp_hash));

    // Start held for 100 cycles: one job, cycle_count matches the measured interval
    arm_model(-1);
    run_job(header2, 100, n);
    check("start_clears_hv", v_t'(first_hv), v_t'(1'b0));
    check("start_clears_hash", v_t'(first_hash), v_t'(0));
    check("start_clears_cnt", v_t'(first_cnt), v_t'(0));
    check("cycle_count", v_t'(cycle_count), v_t'(n - 1));
    check("rx_block_held_start", rx_block, header2);
    check("ack_count_held_start", v_t'(ack_count), v_t'(32));
    repeat (20) @(negedge clk);
    check("single_job_busy", v_t'(busy), v_t'(1'b0));
    check("single_job_hv", v_t'(hash_valid), v_t'(1'b1));

    // Abort in the read phase at addr 10
    arm_model(-1);
    header = genesis; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (mbyte != 10 && guard < 3000) begin @(negedge clk); guard++; end
    check("reach_addr10", v_t'(mbyte), v_t'(10));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", v_t'(busy), v_t'(1'b0));
    check("abort_dev_ui", v_t'(dev_ui), v_t'(0));
    check("abort_dev_uio_in", v_t'(dev_uio_in), v_t'(0));
    check("abort_hash_valid", v_t'(hash_valid), v_t'(1'b0));
    repeat (5) @(negedge clk);
    check("abort_stays_idle", v_t'(busy), v_t'(1'b0));
    arm_model(-1);
    run_job(genesis, 1, n);
    check("after_abort_hash", v_t'(hash), v_t'(exp_hash));
    check("after_abort_acks", v_t'(ack_count), v_t'(32));

    // Reset during word 20
    arm_model(-1);
    header = header2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (mword != 20 && guard < 3000) begin @(negedge clk); guard++; end
    check("reach_word20", v_t'(mword), v_t'(20));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", v_t'(busy), v_t'(1'b0));
    check("midrst_hash_valid", v_t'(hash_valid), v_t'(1'b0));
    check("midrst_error", v_t'(error), v_t'(1'b0));
    check("midrst_hash", v_t'(hash), v_t'(0));
    check("midrst_cycle_count", v_t'(cycle_count), v_t'(0));
    check("midrst_dev_ui", v_t'(dev_ui), v_t'(0));
    check("midrst_dev_uio_in", v_t'(dev_uio_in), v_t'(0));
    arm_model(-1);
    run_job(genesis, 1, n);
    check("after_rst_rx_block", rx_block, genesis);
    check("after_rst_hash", v_t'(hash), v_t'(exp_hash));

    // Device stalls after word 5: timeout in WR_RQ_HI
    arm_model(5);
    header = genesis; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (ms != MHalt && guard < 3000) begin @(negedge clk); guard++; end
    check("model_halted", v_t'(ms == MHalt), v_t'(1'b1));
    while (cyc < drop_cyc + 60) @(negedge clk);
    check("no_error_early", v_t'(error), v_t'(1'b0));
    check("busy_before_timeout", v_t'(busy), v_t'(1'b1));
    while (cyc < drop_cyc + 72) @(negedge clk);
    check("timeout_error", v_t'(error), v_t'(1'b1));
    check("timeout_busy", v_t'(busy), v_t'(1'b0));
    check("timeout_dev_ui", v_t'(dev_ui), v_t'(0));
    check("timeout_dev_uio_in", v_t'(dev_uio_in), v_t'(0));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("err_ignores_start_busy", v_t'(busy), v_t'(1'b0));
    check("err_ignores_start_error", v_t'(error), v_t'(1'b1));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_clears_error", v_t'(error), v_t'(1'b0));
    check("abort_from_err_busy", v_t'(busy), v_t'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
